johnson_phase_sequencer: RTL
============================

Name: johnson_phase_sequencer

Overview:
- Controller that sequences a parameterised N-stage Johnson counter, producing 2N evenly spaced phases for multi-phase enable and strobe generation.
- Adds start/stop/hold control, per-run direction, a programmable run length in full rotations, and done/busy status.
- A one-hot phase decode and a binary phase index are provided so downstream logic never decodes Johnson codes itself.
- Sits between a control register block and phase-driven datapath enables.

Parameters:
- N_STAGES, 4, Johnson counter width; the sequence has 2*N_STAGES states (N_STAGES >= 2).
- CYCLE_W, 8, width of the run-length and completed-rotation counters.
- PHASE_W (localparam), clog2(2*N_STAGES), width of Phase_idx.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a run; sampled in IDLE only.
- Stop  in  1  abort the run; highest priority after Reset.
- Hold  in  1  freeze the counter while in RUN.
- Dir  in  1  0 = forward, 1 = reverse; latched at Start.
- Num_cycles  in  CYCLE_W  rotations to run; 0 = run until Stop; latched at Start.
- Count_out  out  N_STAGES  raw Johnson state.
- Phase_idx  out  PHASE_W  binary index of the current state, 0..2N-1.
- Phase_out  out  2*N_STAGES  one-hot decode of Phase_idx.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse on normal completion.
- Cycles_done  out  CYCLE_W  completed rotations in the current or last run.

Behaviour:
- Reset values (win over all other inputs):
  - FSM = IDLE, Count_out = 0, Phase_idx = 0, Phase_out = 1 (bit 0 set).
  - Busy = 0, Done = 0, Cycles_done = 0.
  - Latched Dir and Num_cycles = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - Count_out is held at 0.
  - Start = 1 with Stop = 0: go to RUN, latch Dir and Num_cycles, clear Cycles_done.
  - Start with Stop both high: stay in IDLE.
- RUN:
  - Busy = 1.
  - Each edge with Stop = 0 and Hold = 0 advances the counter:
    - Forward: next = {q[N-2:0], ~q[N-1]}.
    - Reverse: next = {~q[0], q[N-1:1]}.
  - Hold = 1 freezes Count_out and Cycles_done.
  - Start is ignored.
- Latency:
  - Start sampled at edge k puts the FSM in RUN after edge k.
  - The first advance happens at edge k+1.
- Wrap (an advance that returns Count_out to 0):
  - Cycles_done increments, modulo 2^CYCLE_W.
  - If latched Num_cycles != 0 and the incremented value equals it, the next state is DONE.
- Stop in RUN:
  - Next state IDLE, Count_out = 0, Cycles_done holds, no Done pulse.
  - Stop wins over Hold, wrap and completion.
  - Stop on a wrapping edge does not increment Cycles_done.
- DONE:
  - Lasts exactly one cycle: Done = 1, Busy = 0, Count_out = 0.
  - Start and Stop are ignored; next state is IDLE.
- Num_cycles = 0 means continuous run:
  - Cycles_done wraps freely.
  - The run ends only by Stop or Reset.
- Phase_idx, combinational from Count_out, independent of Dir:
  - MSB = 0: popcount(Count_out).
  - MSB = 1: 2N - popcount(Count_out).
  - Forward steps 0,1,..,2N-1,0; reverse steps 0,2N-1,..,1,0.
- Phase_out = 1 << Phase_idx, exactly one bit set at all times.
- Reset mid-run returns everything to reset values at that edge, with no Done pulse.
- Changes to Dir or Num_cycles during RUN have no effect until the next Start.

Test Plan:
- Reset, then Start at edge 0 with Num_cycles = 1, Dir = 0:
  - Count_out after edges 1..8: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - Phase_idx 1..7 then 0; Cycles_done = 1 after edge 8.
  - Done = 1 and Busy = 0 for the one cycle after edge 8; IDLE after edge 9.
- Start with Num_cycles = 2, Dir = 1:
  - Count_out after edges 1..8: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
  - Phase_idx 7 down to 0; pattern repeats, Done pulses after edge 16, Cycles_done = 2.
- Num_cycles = 1, Hold high at edges 3-5:
  - Count_out stays 0011 during the hold.
  - Done is delayed by 3 cycles, to after edge 11.
- Num_cycles = 0, run 20 edges, then Stop:
  - Cycles_done = 2, Count_out = 0 after the Stop edge.
  - Done never asserts.
  - Stop coinciding with a wrap edge leaves Cycles_done unincremented.
- Start pulsed during RUN and during DONE is ignored.
- Start with Stop both high in IDLE leaves the FSM in IDLE.
- Reset asserted mid-run at Count_out = 0111 returns all outputs to reset values at that edge, with Phase_out = 00000001.

Source files
------------

// File: rtl/johnson_phase_sequencer.sv
// Johnson-counter phase sequencer: start/stop/hold control, per-run direction,
// run length in full rotations, and a binary/one-hot phase decode.
module johnson_phase_sequencer #(
    parameter  int N_STAGES = 4,
    parameter  int CYCLE_W  = 8,
    localparam int PHASE_W  = $clog2(2 * N_STAGES)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_hold,
    input  logic                  i_dir,
    input  logic [CYCLE_W-1:0]    i_num_cycles,
    output logic [N_STAGES-1:0]   o_count,
    output logic [PHASE_W-1:0]    o_phase_idx,
    output logic [2*N_STAGES-1:0] o_phase,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CYCLE_W-1:0]    o_cycles_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [N_STAGES-1:0] r_count;
    logic [CYCLE_W-1:0]  r_cycles_done;
    logic [CYCLE_W-1:0]  r_num_cycles;
    logic                r_dir;
    logic                r_busy;
    logic                r_done;

    logic [N_STAGES-1:0]   w_fwd;
    logic [N_STAGES-1:0]   w_rev;
    logic [N_STAGES-1:0]   w_next;
    logic                  w_wrap;
    logic [CYCLE_W-1:0]    w_cyc_inc;
    logic [PHASE_W:0]      w_ones;
    logic [PHASE_W:0]      w_idx_full;
    logic [PHASE_W-1:0]    w_phase_idx;
    logic [2*N_STAGES-1:0] w_phase;

    assign w_fwd     = {r_count[N_STAGES-2:0], ~r_count[N_STAGES-1]};
    assign w_rev     = {~r_count[0], r_count[N_STAGES-1:1]};
    assign w_next    = r_dir ? w_rev : w_fwd;
    assign w_wrap    = (w_next == '0);
    assign w_cyc_inc = r_cycles_done + CYCLE_W'(1);

    // Johnson codes with MSB clear are the "filling" half; index = number of ones.
    always_comb begin
        w_ones = '0;
        for (int i = 0; i < N_STAGES; i++)
            w_ones = w_ones + (PHASE_W + 1)'(r_count[i]);
        w_idx_full  = r_count[N_STAGES-1] ? ((PHASE_W + 1)'(2 * N_STAGES) - w_ones) : w_ones;
        w_phase_idx = w_idx_full[PHASE_W-1:0];
        w_phase     = '0;
        w_phase[w_phase_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_cycles_done <= '0;
            r_num_cycles  <= '0;
            r_dir         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    r_done  <= 1'b0;
                    if (i_start && !i_stop) begin
                        r_state       <= S_RUN;
                        r_busy        <= 1'b1;
                        r_dir         <= i_dir;
                        r_num_cycles  <= i_num_cycles;
                        r_cycles_done <= '0;
                    end
                end
                S_RUN: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else if (!i_hold) begin
                        r_count <= w_next;
                        if (w_wrap) begin
                            r_cycles_done <= w_cyc_inc;
                            if (r_num_cycles != '0 && w_cyc_inc == r_num_cycles) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_count <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign o_count       = r_count;
    assign o_phase_idx   = w_phase_idx;
    assign o_phase       = w_phase;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_cycles_done = r_cycles_done;

endmodule
